// File: rtl/seletor_alvo_pkg.sv
// Shared types for the night-action target selector: class codes, FSM states
// and the helper that tells which classes act at night.
package seletor_alvo_pkg;

    typedef enum logic [1:0] {
        CLASSE_ALDEAO   = 2'b00,
        CLASSE_LOBO     = 2'b01,
        CLASSE_PROTETOR = 2'b10,
        CLASSE_NENHUMA  = 2'b11
    } classe_t;

    // FIM needs its own code, so the state is 3 bits; db_estado shows the 2 LSBs.
    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        BUSCA  = 3'd1,
        ESPERA = 3'd2,
        EMITE  = 3'd3,
        FIM    = 3'd4
    } estado_t;

    function automatic logic classe_age(input classe_t classe);
        return (classe == CLASSE_LOBO) || (classe == CLASSE_PROTETOR);
    endfunction

endpackage

// File: rtl/seletor_alvo_if.sv
// Night-action interface between the control unit/datapath and the target selector.
interface seletor_alvo_if #(
    parameter int unsigned N_JOG = 5,
    parameter int unsigned W_JOG = 3
);
    logic             iniciar;
    logic [W_JOG-1:0] jogador_atual;
    logic [1:0]       classe_atual;
    logic [N_JOG-1:0] mortes;
    logic [W_JOG-1:0] jogador_escolhido;
    logic             processar_acao;
    logic             concluido;
    logic             sem_alvo;
    logic             selecionando;

    modport master (
        output iniciar, jogador_atual, classe_atual, mortes,
        input  jogador_escolhido, processar_acao, concluido, sem_alvo, selecionando
    );

    modport slave (
        input  iniciar, jogador_atual, classe_atual, mortes,
        output jogador_escolhido, processar_acao, concluido, sem_alvo, selecionando
    );
endinterface

// File: rtl/seletor_alvo_edge_detector.sv
// Rising-edge detector for an already synchronized button level.
module seletor_alvo_edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic borda
);
    logic anterior_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) anterior_q <= 1'b0;
        else       anterior_q <= sinal;
    end

    assign borda = sinal & ~anterior_q;
endmodule

// File: rtl/seletor_alvo.sv
// Night-action target selector: walks living players, lets the user step/confirm,
// then emits the chosen target with a one-cycle processar_acao pulse.
module seletor_alvo
    import seletor_alvo_pkg::*;
#(
    parameter int unsigned N_JOG = 5,
    parameter int unsigned W_JOG = 3
) (
    input  logic          clock,
    input  logic          reset,
    seletor_alvo_if.slave bus,
    input  logic          botao_proximo,
    input  logic          botao_confirma,
    output logic [1:0]    db_estado
);
    estado_t          estado_q, estado_d;
    classe_t          classe_q;
    logic [W_JOG-1:0] jogador_q;
    logic [N_JOG-1:0] mortes_q;
    logic [W_JOG-1:0] cand_q, cand_d, cand_mais;
    logic [W_JOG-1:0] passos_q, passos_d;
    logic             sem_alvo_q, sem_alvo_d;
    logic             processar_q, concluido_q, selecionando_q;
    logic             borda_proximo, borda_confirma;
    logic             aceita, cand_valido;

    seletor_alvo_edge_detector u_borda_proximo (
        .clock (clock),
        .reset (reset),
        .sinal (botao_proximo),
        .borda (borda_proximo)
    );

    seletor_alvo_edge_detector u_borda_confirma (
        .clock (clock),
        .reset (reset),
        .sinal (botao_confirma),
        .borda (borda_confirma)
    );

    assign aceita      = (estado_q == OCIOSO) && bus.iniciar;
    assign cand_mais   = (cand_q == W_JOG'(N_JOG - 1)) ? '0 : cand_q + W_JOG'(1);
    // A protector may choose himself; a wolf may not.
    assign cand_valido = !mortes_q[cand_q] &&
                         ((classe_q == CLASSE_PROTETOR) || (cand_q != jogador_q));

    always_comb begin
        estado_d   = estado_q;
        cand_d     = cand_q;
        passos_d   = passos_q;
        sem_alvo_d = sem_alvo_q;
        case (estado_q)
            OCIOSO: begin
                if (bus.iniciar) begin
                    sem_alvo_d = 1'b0;
                    if (classe_age(classe_t'(bus.classe_atual))) begin
                        estado_d = BUSCA;
                        cand_d   = '0;
                        passos_d = '0;
                    end else begin
                        estado_d = FIM;
                    end
                end
            end
            BUSCA: begin
                if (cand_valido) begin
                    estado_d = ESPERA;
                end else if (passos_q == W_JOG'(N_JOG - 1)) begin
                    estado_d   = FIM;
                    sem_alvo_d = 1'b1;
                end else begin
                    cand_d   = cand_mais;
                    passos_d = passos_q + W_JOG'(1);
                end
            end
            ESPERA: begin
                // Confirm has priority when both buttons rise together.
                if (borda_confirma) begin
                    estado_d = EMITE;
                end else if (borda_proximo) begin
                    estado_d = BUSCA;
                    cand_d   = cand_mais;
                    passos_d = '0;
                end
            end
            EMITE:   estado_d = OCIOSO;
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q       <= OCIOSO;
            classe_q       <= CLASSE_ALDEAO;
            jogador_q      <= '0;
            mortes_q       <= '0;
            cand_q         <= '0;
            passos_q       <= '0;
            sem_alvo_q     <= 1'b0;
            processar_q    <= 1'b0;
            concluido_q    <= 1'b0;
            selecionando_q <= 1'b0;
        end else begin
            if (aceita) begin
                classe_q  <= classe_t'(bus.classe_atual);
                jogador_q <= bus.jogador_atual;
                mortes_q  <= bus.mortes;
            end
            estado_q       <= estado_d;
            cand_q         <= cand_d;
            passos_q       <= passos_d;
            sem_alvo_q     <= sem_alvo_d;
            processar_q    <= (estado_d == EMITE);
            concluido_q    <= (estado_d == EMITE) || (estado_d == FIM);
            selecionando_q <= (estado_d == BUSCA) || (estado_d == ESPERA);
        end
    end

    assign bus.jogador_escolhido = cand_q;
    assign bus.processar_acao    = processar_q;
    assign bus.concluido         = concluido_q;
    assign bus.sem_alvo          = sem_alvo_q;
    assign bus.selecionando      = selecionando_q;
    assign db_estado             = estado_q[1:0];
endmodule

// File: tb/tb_seletor_alvo.sv
// Directed bench for seletor_alvo: scenario tasks with hand-computed expectations.
module tb_seletor_alvo;
    localparam int unsigned N_JOG = 5;
    localparam int unsigned W_JOG = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       botao_proximo = 1'b0;
    logic       botao_confirma = 1'b0;
    logic [1:0] db_estado;
    int         checks = 0;
    int         errors = 0;

    seletor_alvo_if #(.N_JOG(N_JOG), .W_JOG(W_JOG)) bus ();

    seletor_alvo #(.N_JOG(N_JOG), .W_JOG(W_JOG)) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .botao_proximo  (botao_proximo),
        .botao_confirma (botao_confirma),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic iniciar_sel(input logic [2:0] jog, input logic [1:0] cls, input logic [4:0] mort);
        bus.jogador_atual = jog;
        bus.classe_atual  = cls;
        bus.mortes        = mort;
        bus.iniciar       = 1'b1;
        step();
        bus.iniciar = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.jogador_escolhido !== 3'd0) begin errors++;
            $display("FAIL reset_escolhido: got %0d expected 0", bus.jogador_escolhido); end
        checks++; if (bus.processar_acao !== 1'b0 || bus.concluido !== 1'b0) begin errors++;
            $display("FAIL reset_pulses: got proc=%b concl=%b expected 0 0",
                     bus.processar_acao, bus.concluido); end
        checks++; if (bus.sem_alvo !== 1'b0 || bus.selecionando !== 1'b0) begin errors++;
            $display("FAIL reset_flags: got sem=%b sel=%b expected 0 0",
                     bus.sem_alvo, bus.selecionando); end
        checks++; if (db_estado !== 2'd0) begin errors++;
            $display("FAIL reset_estado: got %0d expected 0", db_estado); end
    endtask

    task automatic test_lobo_basico();
        iniciar_sel(3'd1, 2'b01, 5'b00000);
        checks++; if (db_estado !== 2'd1 || bus.selecionando !== 1'b1) begin errors++;
            $display("FAIL basico_busca: got est=%0d sel=%b expected 1 1",
                     db_estado, bus.selecionando); end
        step();
        checks++; if (db_estado !== 2'd2 || bus.jogador_escolhido !== 3'd0) begin errors++;
            $display("FAIL basico_espera: got est=%0d esc=%0d expected 2 0",
                     db_estado, bus.jogador_escolhido); end
        botao_confirma = 1'b1;
        step();
        checks++; if (bus.processar_acao !== 1'b1 || bus.concluido !== 1'b1 ||
                      bus.jogador_escolhido !== 3'd0) begin errors++;
            $display("FAIL basico_emite: got proc=%b concl=%b esc=%0d expected 1 1 0",
                     bus.processar_acao, bus.concluido, bus.jogador_escolhido); end
        botao_confirma = 1'b0;
        step();
        checks++; if (bus.processar_acao !== 1'b0 || bus.concluido !== 1'b0 ||
                      db_estado !== 2'd0) begin errors++;
            $display("FAIL basico_fim_pulso: got proc=%b concl=%b est=%0d expected 0 0 0",
                     bus.processar_acao, bus.concluido, db_estado); end
    endtask

    task automatic test_pula_e_proximo();
        iniciar_sel(3'd0, 2'b01, 5'b00110);
        // Inputs changed after iniciar must be ignored.
        bus.mortes = 5'b11111;
        bus.jogador_atual = 3'd3;
        repeat (3) step();
        checks++; if (db_estado !== 2'd1) begin errors++;
            $display("FAIL pula_latencia: got est=%0d expected 1", db_estado); end
        step();
        checks++; if (db_estado !== 2'd2 || bus.jogador_escolhido !== 3'd3) begin errors++;
            $display("FAIL pula_espera: got est=%0d esc=%0d expected 2 3",
                     db_estado, bus.jogador_escolhido); end
        bus.iniciar = 1'b1;
        step();
        bus.iniciar = 1'b0;
        checks++; if (db_estado !== 2'd2 || bus.jogador_escolhido !== 3'd3) begin errors++;
            $display("FAIL pula_iniciar_ignorado: got est=%0d esc=%0d expected 2 3",
                     db_estado, bus.jogador_escolhido); end
        botao_proximo = 1'b1;
        step();
        botao_proximo = 1'b0;
        checks++; if (db_estado !== 2'd1 || bus.jogador_escolhido !== 3'd4) begin errors++;
            $display("FAIL pula_proximo_busca: got est=%0d esc=%0d expected 1 4",
                     db_estado, bus.jogador_escolhido); end
        step();
        checks++; if (db_estado !== 2'd2 || bus.jogador_escolhido !== 3'd4) begin errors++;
            $display("FAIL pula_proximo_4: got est=%0d esc=%0d expected 2 4",
                     db_estado, bus.jogador_escolhido); end
        botao_proximo = 1'b1;
        step();
        botao_proximo = 1'b0;
        checks++; if (bus.jogador_escolhido !== 3'd0) begin errors++;
            $display("FAIL pula_wrap: got esc=%0d expected 0", bus.jogador_escolhido); end
        repeat (4) step();
        checks++; if (db_estado !== 2'd2 || bus.jogador_escolhido !== 3'd3) begin errors++;
            $display("FAIL pula_wrap_espera: got est=%0d esc=%0d expected 2 3",
                     db_estado, bus.jogador_escolhido); end
        botao_confirma = 1'b1;
        step();
        botao_confirma = 1'b0;
        checks++; if (bus.processar_acao !== 1'b1 || bus.jogador_escolhido !== 3'd3) begin errors++;
            $display("FAIL pula_emite: got proc=%b esc=%0d expected 1 3",
                     bus.processar_acao, bus.jogador_escolhido); end
        step();
    endtask

    task automatic test_protetor_proprio();
        iniciar_sel(3'd2, 2'b10, 5'b11011);
        repeat (3) step();
        checks++; if (db_estado !== 2'd2 || bus.jogador_escolhido !== 3'd2) begin errors++;
            $display("FAIL protetor_espera: got est=%0d esc=%0d expected 2 2",
                     db_estado, bus.jogador_escolhido); end
        botao_confirma = 1'b1;
        step();
        botao_confirma = 1'b0;
        checks++; if (bus.processar_acao !== 1'b1 || bus.jogador_escolhido !== 3'd2) begin errors++;
            $display("FAIL protetor_emite: got proc=%b esc=%0d expected 1 2",
                     bus.processar_acao, bus.jogador_escolhido); end
        step();
    endtask

    task automatic test_sem_alvo();
        int n_proc = 0;
        iniciar_sel(3'd4, 2'b01, 5'b01111);
        repeat (4) begin
            step();
            if (bus.processar_acao === 1'b1) n_proc++;
        end
        checks++; if (bus.concluido !== 1'b0 || db_estado !== 2'd1) begin errors++;
            $display("FAIL sem_alvo_cedo: got concl=%b est=%0d expected 0 1",
                     bus.concluido, db_estado); end
        step();
        if (bus.processar_acao === 1'b1) n_proc++;
        checks++; if (bus.concluido !== 1'b1 || bus.sem_alvo !== 1'b1) begin errors++;
            $display("FAIL sem_alvo_fim: got concl=%b sem=%b expected 1 1",
                     bus.concluido, bus.sem_alvo); end
        checks++; if (n_proc != 0) begin errors++;
            $display("FAIL sem_alvo_proc: got %0d pulses expected 0", n_proc); end
        step();
        checks++; if (bus.concluido !== 1'b0 || bus.sem_alvo !== 1'b1) begin errors++;
            $display("FAIL sem_alvo_mantem: got concl=%b sem=%b expected 0 1",
                     bus.concluido, bus.sem_alvo); end
    endtask

    task automatic test_aldeao();
        iniciar_sel(3'd3, 2'b00, 5'b00000);
        checks++; if (bus.concluido !== 1'b1 || bus.processar_acao !== 1'b0) begin errors++;
            $display("FAIL aldeao_concluido: got concl=%b proc=%b expected 1 0",
                     bus.concluido, bus.processar_acao); end
        checks++; if (bus.sem_alvo !== 1'b0) begin errors++;
            $display("FAIL aldeao_limpa_sem_alvo: got %b expected 0", bus.sem_alvo); end
        step();
        checks++; if (bus.concluido !== 1'b0 || db_estado !== 2'd0) begin errors++;
            $display("FAIL aldeao_pos: got concl=%b est=%0d expected 0 0",
                     bus.concluido, db_estado); end
        iniciar_sel(3'd0, 2'b11, 5'b00000);
        checks++; if (bus.concluido !== 1'b1 || bus.selecionando !== 1'b0) begin errors++;
            $display("FAIL nenhuma_concluido: got concl=%b sel=%b expected 1 0",
                     bus.concluido, bus.selecionando); end
        step();
    endtask

    task automatic test_confirma_segurado();
        int n_proc = 0;
        int n_concl = 0;
        iniciar_sel(3'd1, 2'b01, 5'b00000);
        step();
        botao_confirma = 1'b1;
        repeat (10) begin
            step();
            if (bus.processar_acao === 1'b1) n_proc++;
            if (bus.concluido === 1'b1) n_concl++;
        end
        botao_confirma = 1'b0;
        checks++; if (n_proc != 1 || n_concl != 1) begin errors++;
            $display("FAIL segurado_pulsos: got proc=%0d concl=%0d expected 1 1", n_proc, n_concl); end
        step();
    endtask

    task automatic test_reset_meio();
        iniciar_sel(3'd0, 2'b10, 5'b00111);
        repeat (4) step();
        checks++; if (db_estado !== 2'd2 || bus.jogador_escolhido !== 3'd3) begin errors++;
            $display("FAIL reset_meio_pre: got est=%0d esc=%0d expected 2 3",
                     db_estado, bus.jogador_escolhido); end
        reset = 1'b1;
        #1;
        checks++; if (db_estado !== 2'd0 || bus.jogador_escolhido !== 3'd0 ||
                      bus.selecionando !== 1'b0) begin errors++;
            $display("FAIL reset_meio_async: got est=%0d esc=%0d sel=%b expected 0 0 0",
                     db_estado, bus.jogador_escolhido, bus.selecionando); end
        #2;
        reset = 1'b0;
        step();
        checks++; if (bus.processar_acao !== 1'b0 || bus.concluido !== 1'b0 ||
                      db_estado !== 2'd0) begin errors++;
            $display("FAIL reset_meio_pos: got proc=%b concl=%b est=%0d expected 0 0 0",
                     bus.processar_acao, bus.concluido, db_estado); end
    endtask

    task automatic test_dois_botoes();
        iniciar_sel(3'd1, 2'b01, 5'b00001);
        repeat (3) step();
        checks++; if (db_estado !== 2'd2 || bus.jogador_escolhido !== 3'd2) begin errors++;
            $display("FAIL dois_espera: got est=%0d esc=%0d expected 2 2",
                     db_estado, bus.jogador_escolhido); end
        botao_proximo  = 1'b1;
        botao_confirma = 1'b1;
        step();
        botao_proximo  = 1'b0;
        botao_confirma = 1'b0;
        checks++; if (bus.processar_acao !== 1'b1 || bus.jogador_escolhido !== 3'd2) begin errors++;
            $display("FAIL dois_confirma_vence: got proc=%b esc=%0d expected 1 2",
                     bus.processar_acao, bus.jogador_escolhido); end
        step();
    endtask

    initial begin
        bus.iniciar       = 1'b0;
        bus.jogador_atual = '0;
        bus.classe_atual  = 2'b00;
        bus.mortes        = '0;
        repeat (2) step();
        test_reset();
        reset = 1'b0;
        step();
        test_lobo_basico();
        test_pula_e_proximo();
        test_protetor_proprio();
        test_sem_alvo();
        test_aldeao();
        test_confirma_segurado();
        test_reset_meio();
        test_dois_botoes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
